// File: rtl/lane_scroll.sv
// One game lane: rotating obstacle ring, one-hot player marker, collision latch.
// Optional build macro LANE_WRAP_EN makes edge moves wrap around the lane.
module lane_scroll #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SPD_W = 8,
  parameter int unsigned DIR   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up,
  input  logic             down,
  input  logic             left,
  input  logic             right,
  input  logic [WIDTH-1:0] init,
  input  logic [SPD_W-1:0] speed,
  input  logic [WIDTH-1:0] pos_above,
  input  logic [WIDTH-1:0] pos_below,
  output logic [WIDTH-1:0] player,
  output logic [WIDTH-1:0] obst,
  output logic             tick,
  output logic             lose
);

  logic [SPD_W-1:0] cnt;
  logic [WIDTH-1:0] obst_rot_c;
  logic [WIDTH-1:0] player_nxt_c;
  logic             hit_c;

  // Ring rotated one position in the configured direction
  always_comb begin
    obst_rot_c = obst;
    if (DIR == 0) obst_rot_c = {obst[0], obst[WIDTH-1:1]};
    else          obst_rot_c = {obst[WIDTH-2:0], obst[WIDTH-1]};
  end

  assign hit_c = |(player & obst);

  // Player move priority: sideways moves beat hops, hops beat leaving
  always_comb begin
    player_nxt_c = player;
    if (left && right) begin
      player_nxt_c = player;
    end else if (left && player[WIDTH-1]) begin
`ifdef LANE_WRAP_EN
      player_nxt_c = WIDTH'(1);
`else
      player_nxt_c = player;
`endif
    end else if (right && player[0]) begin
`ifdef LANE_WRAP_EN
      player_nxt_c = {1'b1, {(WIDTH-1){1'b0}}};
`else
      player_nxt_c = player;
`endif
    end else if (left) begin
      player_nxt_c = {player[WIDTH-2:0], 1'b0};
    end else if (right) begin
      player_nxt_c = {1'b0, player[WIDTH-1:1]};
    end else if (up && (pos_below != '0)) begin
      player_nxt_c = pos_below;
    end else if (down && (pos_above != '0)) begin
      player_nxt_c = pos_above;
    end else if ((up || down) && (player != '0)) begin
      player_nxt_c = '0;
    end
  end

  // Divider, ring, player and sticky lose; everything freezes once lost
  always_ff @(posedge clk) begin
    if (reset) begin
      player <= '0;
      obst   <= init;
      cnt    <= '0;
      tick   <= 1'b0;
      lose   <= 1'b0;
    end else if (lose) begin
      tick <= 1'b0;
    end else begin
      lose   <= hit_c;
      player <= player_nxt_c;
      if (speed == '0) begin
        cnt  <= '0;
        tick <= 1'b0;
      end else if (cnt >= speed) begin
        cnt  <= '0;
        obst <= obst_rot_c;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + SPD_W'(1);
        tick <= 1'b0;
      end
    end
  end

endmodule
